// File: rtl/seg595_pkg.sv
// Shared types and constants for the 74HC595 segment driver.
package seg595_pkg;

  localparam int unsigned FRAME_BITS = 8;

  typedef enum logic [1:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StLatch
  } state_e;

  // Busy cycles per frame: 16 shift half-periods plus one latch phase.
  function automatic int unsigned frame_cycles(input int unsigned div);
    return 17 * div;
  endfunction

endpackage

// File: rtl/seg595_tick.sv
// DIV-cycle phase divider: done is high in the last cycle of each phase.
module seg595_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic done
);

  logic [7:0] cnt_q;

  assign done = (cnt_q == 8'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clear || done) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/seg595_driver.sv
// Serialises one {dp, seg[6:0]} byte MSB first into a 74HC595, then strobes its latch.
module seg595_driver
  import seg595_pkg::*;
#(
  parameter int unsigned DIV    = 4,
  parameter bit          INVERT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic       valid,
  output logic       ready,
  output logic       sclk,
  output logic       sdata,
  output logic       latch,
  output logic       busy
);

  state_e                state_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic [2:0]            bit_cnt_q;
  logic [FRAME_BITS-1:0] frame;
  logic                  phase_done;

  assign frame = {dp_in, seg_in} ^ (INVERT ? {FRAME_BITS{1'b1}} : {FRAME_BITS{1'b0}});
  assign busy  = ~ready;

  // Divider is held cleared while idle so every frame starts at phase count 0.
  seg595_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state_q == StIdle),
    .done (phase_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sclk      <= 1'b0;
      sdata     <= 1'b0;
      latch     <= 1'b0;
      ready     <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid) begin
            shreg_q   <= frame;
            bit_cnt_q <= 3'(FRAME_BITS - 1);
            sdata     <= frame[FRAME_BITS-1];
            ready     <= 1'b0;
            state_q   <= StShiftLo;
          end
        end
        StShiftLo: begin
          if (phase_done) begin
            sclk    <= 1'b1;
            state_q <= StShiftHi;
          end
        end
        StShiftHi: begin
          if (phase_done) begin
            sclk <= 1'b0;
            if (bit_cnt_q == 3'd0) begin
              sdata   <= 1'b0;
              latch   <= 1'b1;
              state_q <= StLatch;
            end else begin
              bit_cnt_q <= bit_cnt_q - 3'd1;
              shreg_q   <= {shreg_q[FRAME_BITS-2:0], 1'b0};
              sdata     <= shreg_q[FRAME_BITS-2];
              state_q   <= StShiftLo;
            end
          end
        end
        StLatch: begin
          if (phase_done) begin
            latch   <= 1'b0;
            ready   <= 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seg595_driver.sv
// Four driver configurations on shared inputs, checked cycle by cycle against a timing model
// and a receiving 74HC595 model.
module tb_seg595_driver;

  localparam int NDUT = 4;

  function automatic int unsigned div_of(input int g);
    case (g)
      0:       return 4;
      1:       return 4;
      2:       return 1;
      default: return 2;
    endcase
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic       dp;
  logic       valid;
  logic [NDUT-1:0] ready_w, busy_w, sclk_w, sdata_w, latch_w;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Reference model state, one entry per instance.
  bit        act_m[NDUT];
  int        start_m[NDUT];
  logic [7:0] frame_m[NDUT];
  int        acc_cnt[NDUT];
  // Receiving 74HC595 model.
  logic [7:0] sh595[NDUT];
  logic [7:0] st595[NDUT];
  int        nsh[NDUT];
  logic      prev_sclk[NDUT];
  logic      prev_latch[NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    seg595_driver #(
      .DIV   (div_of(g)),
      .INVERT(g == 1)
    ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .seg_in(seg),
      .dp_in (dp),
      .valid (valid),
      .ready (ready_w[g]),
      .sclk  (sclk_w[g]),
      .sdata (sdata_w[g]),
      .latch (latch_w[g]),
      .busy  (busy_w[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int g, input int limit);
    int base;
    base = acc_cnt[g];
    for (int i = 0; i < limit; i++) begin
      step(1);
      if (acc_cnt[g] != base) return;
    end
    check_eq("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic pulse(input logic [6:0] s, input logic d);
    seg   = s;
    dp    = d;
    valid = 1'b1;
    step(1);
    valid = 1'b0;
  endtask

  // Model: frame of 17*DIV busy cycles after the accept edge, sampled mid-cycle.
  initial begin
    int d, t, ph;
    logic [4:0] exp_o, got_o;
    for (int g = 0; g < NDUT; g++) begin
      act_m[g] = 0; start_m[g] = 0; frame_m[g] = '0; acc_cnt[g] = 0;
      sh595[g] = '0; st595[g] = '0; nsh[g] = 0; prev_sclk[g] = 0; prev_latch[g] = 0;
    end
    forever begin
      @(negedge clk);
      if (cyc >= 1) begin
        for (int g = 0; g < NDUT; g++) begin
          d = int'(div_of(g));
          t = cyc - start_m[g];
          if (act_m[g]) begin
            ph = (t - 1) / d;
            if (ph < 16) exp_o = {1'b0, 1'b1, ph % 2 == 1, frame_m[g][7 - ph / 2], 1'b0};
            else exp_o = 5'b01001;
          end else begin
            exp_o = 5'b10000;
          end
          got_o = {ready_w[g], busy_w[g], sclk_w[g], sdata_w[g], latch_w[g]};
          check_eq($sformatf("wave%0d", g), 32'(got_o), 32'(exp_o));

          if (sclk_w[g] && !prev_sclk[g]) begin
            sh595[g] = {sh595[g][6:0], sdata_w[g]};
            nsh[g]++;
          end
          if (latch_w[g] && !prev_latch[g]) begin
            st595[g] = sh595[g];
            check_eq($sformatf("latch_byte%0d", g), 32'(st595[g]), 32'(frame_m[g]));
            check_eq($sformatf("sclk_edges%0d", g), 32'(nsh[g]), 32'd8);
          end
          prev_sclk[g]  = sclk_w[g];
          prev_latch[g] = latch_w[g];

          if (!rst_n) begin
            act_m[g] = 0;
          end else if (act_m[g]) begin
            if (t == 17 * d) act_m[g] = 0;
          end else if (valid) begin
            act_m[g]   = 1;
            start_m[g] = cyc;
            frame_m[g] = {dp, seg} ^ ((g == 1) ? 8'hFF : 8'h00);
            nsh[g]     = 0;
            acc_cnt[g]++;
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] v8;
    rst_n = 1'b0;
    valid = 1'b0;
    seg   = '0;
    dp    = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    // 0x3F frame, plain and inverted, DIV=4 timing.
    pulse(7'h3F, 1'b0);
    step(80);
    check_eq("plain_3f", 32'(st595[0]), 32'h3F);
    check_eq("invert_3f", 32'(st595[1]), 32'hC0);

    // Valid during bit 3 high phase must not disturb the frame in flight.
    pulse(7'h06, 1'b0);
    step(37);
    pulse(7'h7F, 1'b1);
    step(40);
    check_eq("midframe_ignored", 32'(st595[0]), 32'h06);

    // Reset during bit 5 aborts without a latch; next frame is whole.
    pulse(7'h5B, 1'b0);
    step(19);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(80);
    check_eq("abort_keep", 32'(st595[0]), 32'h06);
    pulse(7'h6D, 1'b0);
    step(75);
    check_eq("after_abort", 32'(st595[0]), 32'h6D);

    // Back-to-back frames on DIV=1 with valid held high.
    seg   = 7'h06;
    valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_acc(2, 40);
      seg = (k % 2 == 0) ? 7'h5B : 7'h06;
    end
    valid = 1'b0;
    step(30);
    check_eq("b2b_last", 32'(st595[2]), 32'h5B);

    // Every byte value through the DIV=2 instance.
    valid = 1'b1;
    for (int v = 0; v < 256; v++) begin
      v8  = 8'(v);
      seg = v8[6:0];
      dp  = v8[7];
      wait_acc(3, 60);
    end
    valid = 1'b0;
    step(40);
    check_eq("sweep_last", 32'(st595[3]), 32'hFF);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      seg   = 7'($urandom);
      dp    = 1'($urandom);
      rst_n = ($urandom_range(0, 39) != 0);
      step(1);
    end
    rst_n = 1'b1;
    valid = 1'b0;
    step(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
